// File: rtl/sorter_pkg.sv
// Shared types for the sorter front end: modulation codes, feeder FSM states
// and the groups-per-frame helper used to size a frame from its modulation.
package sorter_pkg;

  typedef enum logic [1:0] {
    MOD_QPSK   = 2'd0,
    MOD_QAM16  = 2'd1,
    MOD_QAM64  = 2'd2,
    MOD_QAM256 = 2'd3
  } mod_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } feeder_state_e;

  localparam int unsigned GROUP_WORDS = 4;

  // Four words per group, so groups = words/4 = 4^M / ... = 1 << (2*M).
  function automatic int unsigned groups_per_frame(input mod_e m);
    return 32'd1 << (32'd2 * 32'(m));
  endfunction

endpackage

// File: rtl/feeder_bank.sv
// Four-slot staging register for one group of metric words; slot 0 is the
// first word received and drives d1 downstream.
module feeder_bank #(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [1:0]            widx_i,
  input  logic [WIDTH-1:0]      wdata_i,
  output logic [3:0][WIDTH-1:0] data_o
);

  logic [3:0][WIDTH-1:0] slot_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= '0;
    end else if (we_i) begin
      slot_q[widx_i] <= wdata_i;
    end
  end

  assign data_o = slot_q;

endmodule

// File: rtl/sorter_feeder.sv
// Packs a serial metric stream into groups of four for the sorter, one group per
// sorter_done. SORTER_FEEDER_PINGPONG_EN adds a second bank prefilled during WAIT.
module sorter_feeder
  import sorter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GRP_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       M,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             sorter_done,
  output logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] d2,
  output logic [WIDTH-1:0] d3,
  output logic [WIDTH-1:0] d4,
  output logic             start,
  output logic [GRP_W-1:0] group_idx,
  output logic             busy,
  output logic             frame_done
);

  feeder_state_e         state_q, state_d;
  mod_e                  m_q, m_d;
  logic [2:0]            wcnt_q, wcnt_d;
  logic [GRP_W-1:0]      grp_q, grp_d;
  logic                  rdy;
  logic                  xfer;
  logic                  last_grp;
  logic [3:0][WIDTH-1:0] grp_data;

  assign last_grp = (32'(grp_q) == (groups_per_frame(m_q) - 32'd1));
  assign in_ready = rdy & ~rst;
  assign xfer     = in_valid & in_ready;

`ifdef SORTER_FEEDER_PINGPONG_EN
  logic                  sel_q, sel_d;
  logic                  wsel;
  logic                  idle_full;
  logic [3:0][WIDTH-1:0] bank0_data, bank1_data;

  // During WAIT the active bank is frozen on d1..d4, so writes go to the other one.
  assign wsel      = (state_q == ST_WAIT) ? ~sel_q : sel_q;
  assign idle_full = (wcnt_q == 3'd4) || (xfer && (wcnt_q == 3'd3));

  feeder_bank #(.WIDTH(WIDTH)) u_bank0 (
    .clk    (clk),
    .rst    (rst),
    .we_i   (xfer & ~wsel),
    .widx_i (wcnt_q[1:0]),
    .wdata_i(in_data),
    .data_o (bank0_data)
  );

  feeder_bank #(.WIDTH(WIDTH)) u_bank1 (
    .clk    (clk),
    .rst    (rst),
    .we_i   (xfer & wsel),
    .widx_i (wcnt_q[1:0]),
    .wdata_i(in_data),
    .data_o (bank1_data)
  );

  assign grp_data = sel_q ? bank1_data : bank0_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q <= 1'b0;
    end else begin
      sel_q <= sel_d;
    end
  end
`else
  feeder_bank #(.WIDTH(WIDTH)) u_bank (
    .clk    (clk),
    .rst    (rst),
    .we_i   (xfer),
    .widx_i (wcnt_q[1:0]),
    .wdata_i(in_data),
    .data_o (grp_data)
  );
`endif

  assign d1 = grp_data[0];
  assign d2 = grp_data[1];
  assign d3 = grp_data[2];
  assign d4 = grp_data[3];

  always_comb begin
    rdy = 1'b0;
    case (state_q)
      ST_IDLE, ST_FILL: rdy = 1'b1;
`ifdef SORTER_FEEDER_PINGPONG_EN
      ST_WAIT:          rdy = ~last_grp && (wcnt_q != 3'd4);
`endif
      default:          rdy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      m_q     <= MOD_QPSK;
      wcnt_q  <= '0;
      grp_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      wcnt_q  <= wcnt_d;
      grp_q   <= grp_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    m_d        = m_q;
    wcnt_d     = wcnt_q;
    grp_d      = grp_q;
    start      = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    group_idx  = grp_q;
`ifdef SORTER_FEEDER_PINGPONG_EN
    sel_d      = sel_q;
`endif
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (xfer) begin
          m_d     = mod_e'(M);
          wcnt_d  = 3'd1;
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (xfer) begin
          if (wcnt_q == 3'd3) begin
            wcnt_d  = '0;
            state_d = ST_ISSUE;
          end else begin
            wcnt_d = wcnt_q + 3'd1;
          end
        end
      end
      ST_ISSUE: begin
        start   = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
`ifdef SORTER_FEEDER_PINGPONG_EN
        if (xfer) begin
          wcnt_d = wcnt_q + 3'd1;
        end
        if (sorter_done) begin
          if (last_grp) begin
            wcnt_d  = '0;
            state_d = ST_DONE;
          end else begin
            grp_d = grp_q + GRP_W'(1);
            sel_d = ~sel_q;
            // A complete prefilled bank skips FILL; a partial one resumes filling.
            if (idle_full) begin
              wcnt_d  = '0;
              state_d = ST_ISSUE;
            end else begin
              wcnt_d  = wcnt_q + {2'b00, xfer};
              state_d = ST_FILL;
            end
          end
        end
`else
        if (sorter_done) begin
          wcnt_d = '0;
          if (last_grp) begin
            state_d = ST_DONE;
          end else begin
            grp_d   = grp_q + GRP_W'(1);
            state_d = ST_FILL;
          end
        end
`endif
      end
      ST_DONE: begin
        frame_done = 1'b1;
        grp_d      = '0;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
